// File: rtl/conv_stream_ctrl_pkg.sv
// Shared types for the FFT convolution stream sequencer.
package conv_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} conv_ctrl_state_t;

    // Output-FIFO depth, which is also the number of credits available after reset.
    function automatic int cred_max(input int depth_bits);
        return 1 << depth_bits;
    endfunction

endpackage

// File: rtl/conv_stream_ctrl_if.sv
// Handshake bundle between the sequencer and the input FIFO, the datapath, the output FIFO and the job host.
interface conv_stream_ctrl_if #(
    parameter int BUFF_DEPTH_BITS = 3,
    parameter int LEN_WIDTH       = 32
);
    logic                     start;
    logic [LEN_WIDTH-1:0]     ctx_length;
    logic                     in_fifo_empty;
    logic                     in_fifo_re;
    logic                     dp_output_valid;
    logic                     out_fifo_re;
    logic                     busy;
    logic                     done;
    logic [BUFF_DEPTH_BITS:0] credits;
    logic                     err_overflow;

    modport slave (
        input  start, ctx_length, in_fifo_empty, dp_output_valid, out_fifo_re,
        output in_fifo_re, busy, done, credits, err_overflow
    );

    modport master (
        output start, ctx_length, in_fifo_empty, dp_output_valid, out_fifo_re,
        input  in_fifo_re, busy, done, credits, err_overflow
    );
endinterface

// File: rtl/conv_stream_ctrl_credit_cnt.sv
// Saturating up/down counter with a reset value; sat_o flags a step that would leave [0, MAX].
module conv_credit_cnt #(
    parameter int WIDTH = 4,
    parameter int INIT  = 0,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             sat_o
);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Simultaneous inc and dec cancel, so they never count as a saturation event.
    always_comb begin
        cnt_d = cnt_q;
        sat_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q == MAX_V) sat_o = 1'b1;
            else                cnt_d = cnt_q + WIDTH'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) sat_o = 1'b1;
            else             cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= INIT_V;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/conv_stream_ctrl.sv
// Job sequencer: pops ctx_length lines into the datapath under output-FIFO credit control, then drains.
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | issuing lines while credits and input data are available
//  DRAIN | all lines issued, waiting for the datapath to empty
//  DONE  | one-cycle done pulse
module conv_stream_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int BUFF_DEPTH_BITS = 3,
    parameter int LEN_WIDTH       = 32
) (
    input logic              clk,
    input logic              reset,
    conv_stream_ctrl_if.slave bus
);
    localparam int CRED_MAX = cred_max(BUFF_DEPTH_BITS);
    localparam int CW       = BUFF_DEPTH_BITS + 1;

    conv_ctrl_state_t     state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] issued_q, issued_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        credits, inflight;
    logic                 cred_sat, infl_sat;
    logic                 issue, drain_empty;

    assign issue = (state_q == RUN) && !bus.in_fifo_empty && (credits != '0) && (issued_q != len_q);

    // Look at the post-edge inflight value so done lands one cycle after the last datapath output.
    assign drain_empty = (inflight == '0) || ((inflight == CW'(1)) && bus.dp_output_valid);

    conv_credit_cnt #(.WIDTH(CW), .INIT(CRED_MAX), .MAX(CRED_MAX)) u_credits (
        .clk   (clk),
        .reset (reset),
        .inc_i (bus.out_fifo_re),
        .dec_i (issue),
        .cnt_o (credits),
        .sat_o (cred_sat)
    );

    conv_credit_cnt #(.WIDTH(CW), .INIT(0), .MAX((1 << CW) - 1)) u_inflight (
        .clk   (clk),
        .reset (reset),
        .inc_i (issue),
        .dec_i (bus.dp_output_valid),
        .cnt_o (inflight),
        .sat_o (infl_sat)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        err_d    = err_q | cred_sat | infl_sat;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d    = bus.ctx_length;
                    issued_d = '0;
                    state_d  = (bus.ctx_length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    issued_d = issued_q + LEN_WIDTH'(1);
                    if (issued_q == len_q - LEN_WIDTH'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_empty) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            issued_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_fifo_re   = issue;
    assign bus.busy         = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done         = (state_q == DONE);
    assign bus.credits      = credits;
    assign bus.err_overflow = err_q;
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Scoreboard bench for conv_stream_ctrl: expected issue/done cycles queued by stimulus, popped by a monitor.
module tb_conv_stream_ctrl;
    localparam int BDB = 3;
    localparam int LW  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   iss_q[$];
    int   done_q[$];

    logic       re_s      = 1'b0;
    logic [2:0] pipe      = '0;
    int         occ       = 0;
    logic       pop_en    = 1'b0;
    logic       pop_force = 1'b0;
    logic       dp_force  = 1'b0;

    conv_stream_ctrl_if #(.BUFF_DEPTH_BITS(BDB), .LEN_WIDTH(LW)) bus ();

    conv_stream_ctrl #(.BUFF_DEPTH_BITS(BDB), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input int len);
        bus.ctx_length = LW'(len);
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    // Datapath with 3-cycle latency plus an output FIFO drained by the downstream consumer.
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            pipe = '0;
            occ  = 0;
            bus.dp_output_valid = 1'b0;
            bus.out_fifo_re     = 1'b0;
        end else begin
            if (bus.dp_output_valid) occ++;
            if (bus.out_fifo_re && occ > 0) occ--;
            pipe = {pipe[1:0], re_s};
            bus.dp_output_valid = pipe[2] | dp_force;
            bus.out_fifo_re     = (pop_en && occ > 0) || pop_force;
        end
    end

    always @(negedge clk) begin
        re_s = bus.in_fifo_re;
        if (rst_n) begin
            if (bus.in_fifo_re) begin
                if (iss_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_issue: in_fifo_re=1 at cycle %0d, none expected", cyc);
                end else chk("issue_cycle", cyc, iss_q.pop_front());
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, none expected", cyc);
                end else chk("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    initial begin
        int   s;
        int   x;
        logic busy_seen;

        bus.start         = 1'b0;
        bus.ctx_length    = '0;
        bus.in_fifo_empty = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_credits", bus.credits, 8);
        chk("rst_in_fifo_re", bus.in_fifo_re, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err_overflow, 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // T1: 5 lines, FIFO full, consumer always ready
        bus.in_fifo_empty = 1'b0;
        pop_en = 1'b1;
        s = cyc;
        for (int k = 1; k <= 5; k++) iss_q.push_back(s + k);
        done_q.push_back(s + 9);
        start_job(5);
        chk("t1_busy_run", bus.busy, 1);
        tick(12);
        chk("t1_iss_left", iss_q.size(), 0);
        chk("t1_done_left", done_q.size(), 0);
        chk("t1_credits", bus.credits, 8);
        chk("t1_busy_idle", bus.busy, 0);

        // T2: credit stall at 8 lines, then 3 pops release exactly 3 more
        pop_en = 1'b0;
        s = cyc;
        for (int k = 1; k <= 8; k++) iss_q.push_back(s + k);
        start_job(20);
        tick(11);
        chk("t2_credits_zero", bus.credits, 0);
        chk("t2_stall_issues", iss_q.size(), 0);
        x = cyc;
        for (int k = 1; k <= 3; k++) iss_q.push_back(x + k);
        pop_force = 1'b1;
        tick(3);
        pop_force = 1'b0;
        tick(3);
        chk("t2_credits_after", bus.credits, 0);
        chk("t2_iss_left", iss_q.size(), 0);
        chk("t2_busy", bus.busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // T3: zero-length job
        s = cyc;
        done_q.push_back(s + 1);
        busy_seen = 1'b0;
        start_job(0);
        for (int k = 0; k < 4; k++) begin
            busy_seen = busy_seen | bus.busy;
            tick();
        end
        chk("t3_busy_never", busy_seen, 0);
        chk("t3_done_left", done_q.size(), 0);

        // T4: issue and pop in the same cycle at credits=4, then a stray datapath output
        s = cyc;
        for (int k = 1; k <= 4; k++) iss_q.push_back(s + k);
        start_job(5);
        tick(4);
        bus.in_fifo_empty = 1'b1;
        tick(3);
        chk("t4_credits_4", bus.credits, 4);
        x = cyc;
        iss_q.push_back(x);
        done_q.push_back(x + 4);
        bus.in_fifo_empty = 1'b0;
        pop_force = 1'b1;
        tick();
        pop_force = 1'b0;
        chk("t4_credits_same", bus.credits, 4);
        tick(7);
        chk("t4_iss_left", iss_q.size(), 0);
        chk("t4_done_left", done_q.size(), 0);
        chk("t4_err_before", bus.err_overflow, 0);
        dp_force = 1'b1;
        tick();
        dp_force = 1'b0;
        chk("t4_err_set", bus.err_overflow, 1);
        tick(3);
        chk("t4_err_held", bus.err_overflow, 1);
        chk("t4_credits_stray", bus.credits, 4);

        // T5: reset after 3 of 10 issued, then a normal 2-line job
        s = cyc;
        for (int k = 1; k <= 3; k++) iss_q.push_back(s + k);
        start_job(10);
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_in_fifo_re", bus.in_fifo_re, 0);
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_done", bus.done, 0);
        chk("t5_rst_err", bus.err_overflow, 0);
        chk("t5_rst_credits", bus.credits, 8);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_iss_left", iss_q.size(), 0);
        pop_en = 1'b1;
        s = cyc;
        iss_q.push_back(s + 1);
        iss_q.push_back(s + 2);
        done_q.push_back(s + 6);
        start_job(2);
        tick(10);
        chk("t5_job_iss_left", iss_q.size(), 0);
        chk("t5_job_done_left", done_q.size(), 0);
        chk("t5_job_credits", bus.credits, 8);

        // T6: start pulses in RUN, DRAIN and DONE are ignored
        s = cyc;
        for (int k = 1; k <= 3; k++) iss_q.push_back(s + k);
        done_q.push_back(s + 7);
        start_job(3);
        tick();
        bus.ctx_length = LW'(7);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(2);
        chk("t6_busy_drain", bus.busy, 1);
        bus.ctx_length = LW'(9);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(10);
        chk("t6_iss_left", iss_q.size(), 0);
        chk("t6_done_left", done_q.size(), 0);
        chk("t6_busy_idle", bus.busy, 0);
        chk("t6_credits", bus.credits, 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
